sha256_msg_sched: RTL and testbench

- Consumer end of the padded-block word stream from the preprocessor: accepts the 16 32-bit message words M0..M15 of one 512-bit block.
- Emits the full SHA-256 message schedule W0..W63, one word per cycle, to the compression core.
- W0..W15 pass through as they arrive. W16..W63 are expanded from a 16-entry sliding window, with stall support from the compression core.

---
 rtl/sha256_pkg.sv | 25 ++
 rtl/sha256_msg_sched.sv | 111 +++++++++++
 tb/tb_sha256_msg_sched.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared SHA-256 definitions for the message scheduler and the compression core.
//   BLK_WORDS      : 32-bit words per 512-bit message block
//   NUM_ROUNDS     : schedule words (rounds) per block
//   sched_state_t  : message scheduler state encoding
//   small_sigma0/1 : message expansion functions
package sha256_pkg;

  localparam int BLK_WORDS  = 16;
  localparam int NUM_ROUNDS = 64;

  typedef enum logic {
    LOAD = 1'b0,
    GEN  = 1'b1
  } sched_state_t;

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// Accepts the 16 message words of one padded 512-bit block and emits the full
// SHA-256 message schedule W0..W63, one word per cycle, with 1-cycle latency.
// W0..W15 echo the input words; W16..W63 are expanded from a 16-word sliding
// window, paced by w_ready from the compression core.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   m_valid  in   upstream word strobe (no backpressure)
//   m_word   in   upstream message word
//   busy     out  expanding W16..W63; upstream must hold off
//   w_ready  in   compression core accepts a word next cycle (used in GEN only)
//   w_valid  out  w_t / w_idx valid
//   w_t      out  schedule word W[t]
//   w_idx    out  round index t
//   w_last   out  w_valid with w_idx == 63
//   err      out  sticky: m_valid arrived while busy
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accept M0..M15 from upstream, echo each as W0..W15
// GEN   | expand W16..W63 from the window, one per w_ready cycle
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic [31:0] m_word,
  output logic        busy,
  input  logic        w_ready,
  output logic        w_valid,
  output logic [31:0] w_t,
  output logic [5:0]  w_idx,
  output logic        w_last,
  output logic        err
);

  localparam logic [5:0] IDX_LAST_M    = 6'(BLK_WORDS - 1);
  localparam logic [5:0] IDX_FIRST_GEN = 6'(BLK_WORDS);
  localparam logic [5:0] IDX_LAST_W    = 6'(NUM_ROUNDS - 1);

  sched_state_t state;
  logic [5:0]   cnt;
  // win[15] is W[t-1], win[0] is W[t-16]
  logic [31:0]  win [BLK_WORDS];
  logic [31:0]  w_new;

  assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LOAD;
      cnt     <= '0;
      busy    <= 1'b0;
      w_valid <= 1'b0;
      w_t     <= '0;
      w_idx   <= '0;
      w_last  <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < BLK_WORDS; i++) win[i] <= '0;
    end else begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
      case (state)
        LOAD: begin
          if (m_valid) begin
            for (int i = 0; i < BLK_WORDS - 1; i++) win[i] <= win[i+1];
            win[BLK_WORDS-1] <= m_word;
            w_valid <= 1'b1;
            w_t     <= m_word;
            w_idx   <= cnt;
            if (cnt == IDX_LAST_M) begin
              state <= GEN;
              busy  <= 1'b1;
              cnt   <= IDX_FIRST_GEN;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        GEN: begin
          // overrun word is simply dropped; expansion is unaffected
          if (m_valid) err <= 1'b1;
          if (w_ready) begin
            for (int i = 0; i < BLK_WORDS - 1; i++) win[i] <= win[i+1];
            win[BLK_WORDS-1] <= w_new;
            w_valid <= 1'b1;
            w_t     <= w_new;
            w_idx   <= cnt;
            w_last  <= (cnt == IDX_LAST_W);
            if (cnt == IDX_LAST_W) begin
              state <= LOAD;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: begin
          state <= LOAD;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched. Expected schedules come from a
// textbook W[t] recurrence over a 64-entry array; a monitor pops and compares
// every w_valid beat.
module tb_sha256_msg_sched;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];
  typedef struct {
    logic [31:0] w;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic [31:0] m_word;
  logic        busy;
  logic        w_ready;
  logic        w_valid;
  logic [31:0] w_t;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cyc = 0;
  int w0_gap = 0;
  int rdy_mode = 0;
  int stall_left = 0;
  bit stall_done = 0;
  exp_t exp_q [$];
  exp_t e;
  logic [31:0] cap [64];

  sha256_msg_sched dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_word(m_word), .busy(busy),
    .w_ready(w_ready), .w_valid(w_valid), .w_t(w_t), .w_idx(w_idx),
    .w_last(w_last), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t model(input blk_t m);
    sched_t w;
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else begin
        s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
    end
    return w;
  endfunction

  task automatic push_expect(input blk_t m, input int n);
    sched_t w;
    exp_t x;
    w = model(m);
    for (int t = 0; t < n; t++) begin
      x.w = w[t];
      x.idx = 6'(t);
      x.last = (t == 63);
      exp_q.push_back(x);
    end
  endtask

  // Monitor: compare every output beat against the scoreboard head
  always @(negedge clk) begin
    cyc++;
    if (rst && w_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got idx %0d w %h expected no output", w_idx, w_t);
      end else begin
        e = exp_q.pop_front();
        check("w_t", w_t, e.w);
        check("w_idx", 32'(w_idx), 32'(e.idx));
        check("w_last", 32'(w_last), 32'(e.last));
      end
      cap[w_idx] = w_t;
      if (w_idx == 6'd0) w0_gap = cyc - last_cyc;
      if (w_last) last_cyc = cyc;
    end
  end

  // w_ready driver: always ready, or random with a 10-cycle stall at t=40
  initial begin
    w_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) w_ready = 1'b1;
      else if (stall_left > 0) begin
        w_ready = 1'b0;
        stall_left--;
      end else if (w_valid && w_idx == 6'd39 && !stall_done) begin
        w_ready = 1'b0;
        stall_left = 9;
        stall_done = 1;
      end else w_ready = 1'($urandom_range(0, 1));
    end
  end

  // Send n words; waits (bounded) for busy low, then first word on the same negedge
  task automatic send_words(input blk_t m, input int n, input int max_gap);
    int k, g;
    k = 0;
    @(negedge clk);
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) check("busy_timeout", 32'(busy), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      m_valid = 1'b1;
      m_word  = m[i];
      g = (max_gap > 0) ? $urandom_range(1, max_gap) : 0;
      repeat (g) begin
        @(negedge clk);
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    m_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  blk_t abc, ones, rnd;
  int k;

  initial begin
    rst = 1'b0;
    m_valid = 1'b0;
    m_word = '0;
    for (int i = 0; i < 16; i++) begin
      abc[i]  = '0;
      ones[i] = 32'hFFFF_FFFF;
      rnd[i]  = $urandom;
    end
    abc[0]  = 32'h6162_6380;
    abc[15] = 32'h0000_0018;

    #1;
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_w_t", w_t, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: abc, contiguous
    push_expect(abc, 64);
    send_words(abc, 16, 0);
    drain();
    check("abc_W16", cap[16], 32'h6162_6380);
    check("abc_W17", cap[17], 32'h000F_0000);
    check("abc_W63", cap[63], 32'h12B1_EDEB);

    // 2: abc with 1..3 idle cycles between words
    push_expect(abc, 64);
    send_words(abc, 16, 3);
    drain();

    // 3: random block, random w_ready with stall at t=40
    rdy_mode = 1;
    stall_done = 0;
    push_expect(rnd, 64);
    send_words(rnd, 16, 2);
    drain();
    check("stall_seen", 32'(stall_done), 32'd1);
    rdy_mode = 0;

    // 4: back-to-back abc then all-ones
    push_expect(abc, 64);
    push_expect(ones, 64);
    send_words(abc, 16, 0);
    send_words(ones, 16, 0);
    drain();
    check("b2b_w0_gap", 32'(w0_gap), 32'd1);

    // 5: overrun at t=30 of GEN
    push_expect(abc, 64);
    send_words(abc, 16, 0);
    k = 0;
    while (!(w_valid && w_idx == 6'd29) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("err_before", 32'(err), 32'd0);
    m_valid = 1'b1;
    m_word  = 32'hDEAD_BEEF;
    @(negedge clk);
    m_valid = 1'b0;
    check("err_set", 32'(err), 32'd1);
    drain();
    check("err_sticky", 32'(err), 32'd1);

    // 6: reset after 7 words, then full block
    push_expect(rnd, 7);
    send_words(rnd, 7, 0);
    @(negedge clk);
    check("partial_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_w_valid", 32'(w_valid), 32'd0);
    check("mid_rst_w_t", w_t, 32'd0);
    check("mid_rst_w_idx", 32'(w_idx), 32'd0);
    check("mid_rst_w_last", 32'(w_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push_expect(abc, 64);
    send_words(abc, 16, 1);
    drain();
    check("final_W63", cap[63], 32'h12B1_EDEB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
